// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums groups of unsigned products coming from the pipelined array
//   multiplier. A group closes after ACC_LEN products, or earlier when
//   i_last accompanies a valid product. Each completed sum is offered on a
//   one-entry ready/valid output register. The upstream multiplier cannot
//   be stalled, so a sum that completes while the output is still held is
//   dropped and the sticky o_overrun flag is raised.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   i_valid    product valid (multiplier o_valid)
//   i_product  unsigned product, 2*DATAWIDTH bits (multiplier Z_final)
//   i_last     closes the current group early (qualified by i_valid)
//   i_clear    discards the partial accumulation
//   o_valid    completed sum available
//   o_ready    consumer accepts the sum
//   o_sum      completed sum, ACCWIDTH bits
//   o_count    number of products in o_sum (1..ACC_LEN)
//   o_overrun  sticky: a completed sum was discarded
module product_accumulator #(
  parameter  int DATAWIDTH = 4,
  parameter  int ACC_LEN   = 4,
  localparam int ACCWIDTH  = 2*DATAWIDTH + $clog2(ACC_LEN),
  localparam int CNTWIDTH  = $clog2(ACC_LEN+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [2*DATAWIDTH-1:0] i_product,
  input  logic                   i_last,
  input  logic                   i_clear,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [ACCWIDTH-1:0]    o_sum,
  output logic [CNTWIDTH-1:0]    o_count,
  output logic                   o_overrun
);

  logic [ACCWIDTH-1:0] acc_q,     acc_d;
  logic [CNTWIDTH-1:0] cnt_q,     cnt_d;
  logic                o_valid_q, o_valid_d;
  logic [ACCWIDTH-1:0] o_sum_q,   o_sum_d;
  logic [CNTWIDTH-1:0] o_count_q, o_count_d;
  logic                ovr_q,     ovr_d;

  // Effective group state for this cycle: a clear (alone or with a product)
  // makes the incoming product the first of a fresh group.
  logic [ACCWIDTH-1:0] acc_base;
  logic [CNTWIDTH-1:0] cnt_base;
  logic [ACCWIDTH-1:0] sum_next;
  logic [CNTWIDTH-1:0] cnt_next;
  logic                complete;
  logic                out_free;

  always_comb begin
    acc_base = (i_clear || cnt_q == '0) ? '0 : acc_q;
    cnt_base = i_clear ? '0 : cnt_q;
    sum_next = acc_base + ACCWIDTH'(i_product);
    cnt_next = cnt_base + CNTWIDTH'(1);
    complete = i_valid && (i_last || cnt_base == CNTWIDTH'(ACC_LEN-1));
    // The holding register can take a new sum if empty or emptying now.
    out_free = !o_valid_q || o_ready;
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_sum_d   = o_sum_q;
    o_count_d = o_count_q;
    ovr_d     = ovr_q;

    // Accumulator / group counter
    if (i_valid) begin
      if (complete) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_next;
        cnt_d = cnt_next;
      end
    end else if (i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end

    // Output holding register
    if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
    if (complete) begin
      if (out_free) begin
        o_valid_d = 1'b1;
        o_sum_d   = sum_next;
        o_count_d = cnt_next;
      end else begin
        // Held sum is kept; the new one is lost.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_sum_q   <= '0;
      o_count_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_sum_q   <= o_sum_d;
      o_count_q <= o_count_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_sum     = o_sum_q;
  assign o_count   = o_count_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator (DATAWIDTH=4, ACC_LEN=4, ACCWIDTH=10).
// Directed vector table covering the listed scenarios, then randomized
// traffic compared against a group-list reference model.
module tb_product_accumulator;

  localparam int DATAWIDTH = 4;
  localparam int ACC_LEN   = 4;
  localparam int ACCWIDTH  = 10;
  localparam int CNTWIDTH  = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid;
  logic [2*DATAWIDTH-1:0] i_product;
  logic                   i_last;
  logic                   i_clear;
  logic                   o_valid;
  logic                   o_ready;
  logic [ACCWIDTH-1:0]    o_sum;
  logic [CNTWIDTH-1:0]    o_count;
  logic                   o_overrun;

  product_accumulator #(.DATAWIDTH(DATAWIDTH), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product),
    .i_last(i_last), .i_clear(i_clear), .o_valid(o_valid), .o_ready(o_ready),
    .o_sum(o_sum), .o_count(o_count), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One record per clock: inputs applied before the edge, outputs expected
  // just after it.
  typedef struct {
    bit rst_n; bit v; int prod; bit last; bit clr; bit rdy;
    bit ev; int esum; int ecnt; bit eovr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst_n, bit v, int prod, bit last, bit clr,
                              bit rdy, bit ev, int esum, int ecnt, bit eovr);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.prod = prod; t.last = last; t.clr = clr;
    t.rdy = rdy; t.ev = ev; t.esum = esum; t.ecnt = ecnt; t.eovr = eovr;
    vecs.push_back(t);
  endfunction

  // Reference model state: products of the open group, and the output slot.
  int  grp[$];
  bit  m_valid;
  int  m_sum;
  int  m_cnt;
  bit  m_ovr;

  function automatic void model_step(bit rst_n, bit v, int prod, bit last,
                                     bit clr, bit rdy);
    bit was_full;
    int s;
    int n;
    bit done;
    if (!rst_n) begin
      grp.delete();
      m_valid = 0; m_sum = 0; m_cnt = 0; m_ovr = 0;
      return;
    end
    was_full = m_valid;
    if (m_valid && rdy) m_valid = 0;
    if (clr) grp.delete();
    done = 0; s = 0; n = 0;
    if (v) begin
      grp.push_back(prod);
      if (last || grp.size() == ACC_LEN) begin
        foreach (grp[k]) s += grp[k];
        n = grp.size();
        done = 1;
        grp.delete();
      end
    end
    if (done) begin
      if (!was_full || rdy) begin
        m_valid = 1; m_sum = s; m_cnt = n;
      end else begin
        m_ovr = 1;
      end
    end
  endfunction

  task automatic drive(bit rst_n, bit v, int prod, bit last, bit clr, bit rdy);
    rst       = rst_n;
    i_valid   = v;
    i_product = prod[2*DATAWIDTH-1:0];
    i_last    = last;
    i_clear   = clr;
    o_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_product = '0; i_last = 1'b0;
    i_clear = 1'b0; o_ready = 1'b0;

    //   rst v  prod last clr rdy | ev sum cnt ovr
    add(0, 0, 0,   0, 0, 1,  0, 0,   0, 0);   // reset state
    // Full group of 225s, ready
    add(1, 1, 225, 0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 225, 0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 225, 0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 225, 0, 0, 1,  1, 900, 4, 0);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 0);
    // Early close, then single-product group (transfer coincides)
    add(1, 1, 10,  0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 20,  1, 0, 1,  1, 30,  2, 0);
    add(1, 1, 7,   1, 0, 1,  1, 7,   1, 0);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 0);
    // Clear alone mid-group
    add(1, 1, 5,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 6,   0, 0, 1,  0, 0,   0, 0);
    add(1, 0, 0,   0, 1, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 2,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 3,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 4,   0, 0, 1,  1, 10,  4, 0);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 0);
    // Clear coincident with a product
    add(1, 1, 5,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 6,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 9,   0, 1, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  1, 12,  4, 0);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 0);
    // Backpressure and overrun
    add(1, 1, 1,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 2,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 3,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 4,   0, 0, 0,  1, 10,  4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 10,  4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 10,  4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 10,  4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 10,  4, 1);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 1);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 1);
    // Back-to-back with transfer and completion on the same edge
    add(0, 0, 0,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 0,  1, 4,   4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 4,   4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 4,   4, 0);
    add(1, 1, 2,   0, 0, 0,  1, 4,   4, 0);
    add(1, 1, 2,   0, 0, 1,  1, 8,   4, 0);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 0);
    // Reset mid-operation with a held output and partial group
    add(1, 1, 1,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 1,   1, 0, 0,  1, 2,   2, 0);
    add(1, 1, 1,   0, 0, 0,  1, 2,   2, 0);
    add(1, 1, 1,   0, 0, 0,  1, 2,   2, 0);
    add(1, 1, 1,   0, 0, 0,  1, 2,   2, 0);
    add(0, 1, 5,   0, 0, 0,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  0, 0,   0, 0);
    add(1, 1, 1,   0, 0, 1,  1, 4,   4, 0);
    add(1, 0, 0,   0, 0, 1,  0, 0,   0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].v, vecs[i].prod, vecs[i].last,
            vecs[i].clr, vecs[i].rdy);
      chk($sformatf("vec%0d o_valid", i), int'(o_valid), int'(vecs[i].ev));
      chk($sformatf("vec%0d o_overrun", i), int'(o_overrun), int'(vecs[i].eovr));
      if (vecs[i].ev || !vecs[i].rst_n) begin
        chk($sformatf("vec%0d o_sum", i), int'(o_sum), vecs[i].esum);
        chk($sformatf("vec%0d o_count", i), int'(o_count), vecs[i].ecnt);
      end
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      bit r_n, v, l, cl, rd;
      int p;
      r_n = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      v   = ($urandom_range(0, 3) != 0);
      p   = int'($urandom_range(0, 255));
      l   = ($urandom_range(0, 4) == 0);
      cl  = ($urandom_range(0, 11) == 0);
      rd  = ($urandom_range(0, 9) < 7);
      model_step(r_n, v, p, l, cl, rd);
      drive(r_n, v, p, l, cl, rd);
      chk($sformatf("rnd%0d o_valid", c), int'(o_valid), int'(m_valid));
      chk($sformatf("rnd%0d o_overrun", c), int'(o_overrun), int'(m_ovr));
      if (m_valid) begin
        chk($sformatf("rnd%0d o_sum", c), int'(o_sum), m_sum);
        chk($sformatf("rnd%0d o_count", c), int'(o_count), m_cnt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Dot-product accumulator that sits directly downstream of the pipelined array multiplier.
- Consumes the multiplier's product/valid stream and sums groups of ACC_LEN products, or shorter groups closed early by i_last.
- Presents each completed sum on a ready/valid output port.
- The multiplier has no backpressure, so input is accepted every valid cycle; output stalls are reported, never propagated upstream.

Parameters:
- DATAWIDTH, 4, multiplier operand width; product width is 2*DATAWIDTH.
- ACC_LEN, 4, products per full group (>=2).
- ACCWIDTH (localparam), 2*DATAWIDTH+$clog2(ACC_LEN), accumulator/sum width; cannot overflow.
- CNTWIDTH (localparam), $clog2(ACC_LEN+1), width of the group count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset.
- i_valid  input  1  product valid; connect to multiplier o_valid.
- i_product  input  2*DATAWIDTH  product; connect to multiplier Z_final.
- i_last  input  1  qualified by i_valid; closes the group early.
- i_clear  input  1  discards the partial accumulation.
- o_valid  output  1  completed sum available.
- o_ready  input  1  consumer accepts the sum.
- o_sum  output  ACCWIDTH  completed sum.
- o_count  output  CNTWIDTH  number of products in o_sum (1..ACC_LEN).
- o_overrun  output  1  sticky; a completed sum was discarded.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst==0 at a clk edge) clears: acc=0, cnt=0, o_valid=0, o_sum=0, o_count=0, o_overrun=0. Reset mid-group discards the partial sum and any held output.
- State is the implicit FSM IDLE (cnt==0) / ACCUM (cnt>0), plus a one-entry output holding register (EMPTY/FULL = o_valid).
- i_valid, not completing: acc <= (cnt==0 ? 0 : acc) + zero-extended i_product; cnt <= cnt+1. IDLE -> ACCUM.
- Completion occurs when i_valid && (i_last || cnt==ACC_LEN-1).
  - Completion target: acc+product (or the product alone if cnt==0), with count cnt+1.
  - In the same edge: acc <= 0 and cnt <= 0, returning to IDLE.
  - Latency: sum is visible on o_sum with o_valid=1 in the cycle after the completing i_valid edge.
- Output handshake: the transfer occurs on a clk edge with o_valid && o_ready.
  - o_sum and o_count are stable while o_valid && !o_ready.
  - o_valid drops after a transfer unless a completion occurs in the same cycle.
- Completion at an edge where the output is empty, or is being transferred (o_valid && o_ready): load o_sum/o_count, o_valid <= 1. Back-to-back sums at full rate are therefore lossless while o_ready=1.
- Completion at an edge with o_valid && !o_ready:
  - The new sum is discarded; the held sum is kept.
  - o_overrun <= 1. It stays set until reset.
  - Accumulator still clears.
- i_clear without i_valid: acc <= 0, cnt <= 0. The output register is unaffected.
- i_clear with i_valid: the partial sum is discarded and the product starts a new group (acc=product, cnt=1). If i_last or ACC_LEN==1-style completion also applies, the group completes with count 1.
- i_last with cnt==0: a single-product group, o_count=1.
- i_last and i_clear are ignored when i_valid=0, except that i_clear still clears on its own.
- Inputs carry no X-propagation requirement when i_valid=0; i_product is ignored then.
- Purely additive unsigned arithmetic. No saturation is needed because ACCWIDTH covers ACC_LEN*(2^(2*DATAWIDTH)-1).

Test Plan (DATAWIDTH=4, ACC_LEN=4, ACCWIDTH=10):
- Full group, output ready: reset, then o_ready=1; i_valid on 4 consecutive cycles with products 225,225,225,225. Required: o_valid=1 for exactly 1 cycle, 1 cycle after the 4th product, with o_sum=900, o_count=4, o_overrun=0.
- Early close and single-product group: products 10,20 with i_last on 20 -> o_sum=30, o_count=2. Then product 7 with i_last at cnt==0 -> o_sum=7, o_count=1.
- Clear mid-group:
  - Products 5,6, then i_clear alone, then 1,2,3,4 -> o_sum=10, o_count=4.
  - Repeat with i_clear coincident with product 9, followed by 1,1,1 -> o_sum=12.
- Backpressure and overrun: o_ready=0; group 1..4 completes, giving o_sum=10. A second group 2,2,2,2 completes while stalled. Required: o_sum stays 10, o_overrun=1. Then raise o_ready: 10 transfers, o_valid drops, o_overrun stays 1.
- Back-to-back groups with o_ready toggled so transfer and completion coincide. Required: both sums (e.g. 4 then 8) are delivered in order, with no overrun.
- Reset mid-operation: accumulate 3 products and hold an unaccepted output, then assert rst=0 for 1 cycle. Required: o_valid=0, o_sum=0, o_overrun=0. A following group 1,1,1,1 yields 4, with no residue.
